// File: rtl/cordic_pkg.sv
// Shared constants and types for the CORDIC phase sequencer.
package cordic_pkg;

    localparam int          ANGLE_W = 32;
    localparam logic [31:0] QUARTER = 32'h4000_0000;
    localparam int          GAIN_K  = 163007430;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } seq_state_t;

    typedef logic [1:0] quadrant_t;

endpackage

// File: rtl/cordic_quadrant_fold.sv
// Combinational quadrant pre-rotation: maps a full-circle phase onto a
// start vector on one of the four axes plus a residual angle in [0, 90deg).
module cordic_quadrant_fold
    import cordic_pkg::*;
#(
    parameter int WIDTH  = 32,
    parameter int GAIN_K = cordic_pkg::GAIN_K
) (
    input  logic [ANGLE_W-1:0] phase,
    output logic [WIDTH-1:0]   x,
    output logic [WIDTH-1:0]   y,
    output logic [ANGLE_W-1:0] angle,
    output logic [1:0]         quadrant
);

    localparam logic [WIDTH-1:0] K_POS = WIDTH'(GAIN_K);
    localparam logic [WIDTH-1:0] K_NEG = ~K_POS + WIDTH'(1);

    quadrant_t q;

    assign q        = quadrant_t'(phase[ANGLE_W-1 -: 2]);
    assign quadrant = q;
    // Residual angle is the phase modulo one quarter turn.
    assign angle    = phase & (QUARTER - 32'd1);

    // Choose the axis-aligned start vector for the quadrant.
    always_comb begin
        x = '0;
        y = '0;
        case (q)
            2'd0: x = K_POS;
            2'd1: y = K_POS;
            2'd2: x = K_NEG;
            default: y = K_NEG;
        endcase
    end

endmodule

// File: rtl/cordic_phase_sequencer.sv
// NCO-style request generator feeding the CORDIC rotation stage. Issues a
// burst (or continuous stream) of quadrant-folded rotation requests under a
// valid/ready handshake.
module cordic_phase_sequencer
    import cordic_pkg::*;
#(
    parameter int WIDTH  = 32,
    parameter int GAIN_K = cordic_pkg::GAIN_K,
    parameter int CNT_W  = 16
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start,
    input  logic               stop,
    input  logic [ANGLE_W-1:0] phase_init,
    input  logic [ANGLE_W-1:0] phase_inc,
    input  logic [CNT_W-1:0]   burst_len,
    input  logic               out_ready,
    output logic               out_valid,
    output logic [WIDTH-1:0]   Xin,
    output logic [WIDTH-1:0]   Yin,
    output logic [ANGLE_W-1:0] angle,
    output logic [1:0]         quadrant,
    output logic               busy,
    output logic               done
);

    seq_state_t         state_reg, state_next;
    logic [ANGLE_W-1:0] acc_reg, acc_next;
    logic [ANGLE_W-1:0] inc_reg, inc_next;
    logic [CNT_W-1:0]   len_reg, len_next;
    logic [CNT_W-1:0]   cnt_reg, cnt_next;

    logic               valid_next, busy_next, done_next;
    logic [WIDTH-1:0]   x_next, y_next;
    logic [ANGLE_W-1:0] angle_next;
    logic [1:0]         quadrant_next;

    logic [ANGLE_W-1:0] fold_phase;
    logic [WIDTH-1:0]   fold_x, fold_y;
    logic [ANGLE_W-1:0] fold_angle;
    logic [1:0]         fold_quadrant;
    logic               load_out;
    logic               fire;

    // The single fold instance sees the phase of whichever sample is presented next.
    cordic_quadrant_fold #(
        .WIDTH  (WIDTH),
        .GAIN_K (GAIN_K)
    ) u_fold (
        .phase    (fold_phase),
        .x        (fold_x),
        .y        (fold_y),
        .angle    (fold_angle),
        .quadrant (fold_quadrant)
    );

    assign fire = out_valid && out_ready;

    // Next-state and output logic: launch on start, advance on transfer, end on count or stop.
    always_comb begin
        state_next    = state_reg;
        acc_next      = acc_reg;
        inc_next      = inc_reg;
        len_next      = len_reg;
        cnt_next      = cnt_reg;
        valid_next    = out_valid;
        busy_next     = busy;
        done_next     = 1'b0;
        fold_phase    = acc_reg + inc_reg;
        load_out      = 1'b0;

        case (state_reg)
            IDLE: begin
                // start wins over a simultaneous stop; stop alone is a no-op here
                if (start) begin
                    acc_next   = phase_init;
                    inc_next   = phase_inc;
                    len_next   = burst_len;
                    cnt_next   = '0;
                    state_next = RUN;
                    valid_next = 1'b1;
                    busy_next  = 1'b1;
                    fold_phase = phase_init;
                    load_out   = 1'b1;
                end
            end
            RUN: begin
                if (fire) begin
                    acc_next = acc_reg + inc_reg;
                    cnt_next = cnt_reg + CNT_W'(1);
                end
                if (stop) begin
                    // A sample transferred alongside stop still counts; nothing more is issued.
                    state_next = IDLE;
                    valid_next = 1'b0;
                    busy_next  = 1'b0;
                end else if (fire) begin
                    if ((len_reg != '0) && (cnt_next == len_reg)) begin
                        state_next = IDLE;
                        valid_next = 1'b0;
                        busy_next  = 1'b0;
                        done_next  = 1'b1;
                    end else begin
                        load_out = 1'b1;
                    end
                end
            end
            default: begin
                state_next = IDLE;
                valid_next = 1'b0;
                busy_next  = 1'b0;
            end
        endcase

        // Output payload only changes when a new sample is presented, so it holds under backpressure.
        x_next        = load_out ? fold_x        : Xin;
        y_next        = load_out ? fold_y        : Yin;
        angle_next    = load_out ? fold_angle    : angle;
        quadrant_next = load_out ? fold_quadrant : quadrant;
    end

    // State, datapath and output registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= IDLE;
            acc_reg   <= '0;
            inc_reg   <= '0;
            len_reg   <= '0;
            cnt_reg   <= '0;
            out_valid <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
            Xin       <= '0;
            Yin       <= '0;
            angle     <= '0;
            quadrant  <= '0;
        end else begin
            state_reg <= state_next;
            acc_reg   <= acc_next;
            inc_reg   <= inc_next;
            len_reg   <= len_next;
            cnt_reg   <= cnt_next;
            out_valid <= valid_next;
            busy      <= busy_next;
            done      <= done_next;
            Xin       <= x_next;
            Yin       <= y_next;
            angle     <= angle_next;
            quadrant  <= quadrant_next;
        end
    end

endmodule

// File: tb/tb_cordic_phase_sequencer.sv
// Scoreboard bench for cordic_phase_sequencer: the driver pushes expected
// samples from a phase-arithmetic model, a monitor pops them on each transfer.
module tb_cordic_phase_sequencer;

    localparam int K = 163007430;

    typedef struct packed {
        logic [31:0] x;
        logic [31:0] y;
        logic [31:0] a;
        logic [1:0]  q;
    } samp_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic        stop = 1'b0;
    logic [31:0] phase_init = '0;
    logic [31:0] phase_inc = '0;
    logic [15:0] burst_len = '0;
    logic        out_ready = 1'b1;
    logic        out_valid;
    logic [31:0] Xin;
    logic [31:0] Yin;
    logic [31:0] angle;
    logic [1:0]  quadrant;
    logic        busy;
    logic        done;

    int    tests = 0;
    int    fails = 0;
    int    xfer_cnt = 0;
    int    done_cnt = 0;
    int    hold_cycles = 0;
    int    ready_mode = 0;   // 0 = high, 1 = random, 2 = low
    samp_t exp_q[$];
    samp_t hold_s;
    logic  hold_valid = 1'b0;

    cordic_phase_sequencer #(
        .WIDTH  (32),
        .GAIN_K (K),
        .CNT_W  (16)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .stop       (stop),
        .phase_init (phase_init),
        .phase_inc  (phase_inc),
        .burst_len  (burst_len),
        .out_ready  (out_ready),
        .out_valid  (out_valid),
        .Xin        (Xin),
        .Yin        (Yin),
        .angle      (angle),
        .quadrant   (quadrant),
        .busy       (busy),
        .done       (done)
    );

    always #5 clk = ~clk;

    // Reference: quarter-turn index and remainder of the phase, start vector on that axis.
    function automatic samp_t model(input logic [31:0] p);
        samp_t s;
        int unsigned q;
        q   = p / 32'h4000_0000;
        s.a = p % 32'h4000_0000;
        s.q = q[1:0];
        s.x = '0;
        s.y = '0;
        case (q)
            0: s.x = K;
            1: s.y = K;
            2: s.x = -K;
            default: s.y = -K;
        endcase
        return s;
    endfunction

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] expv);
        tests++;
        if (got !== expv) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, got, expv);
        end
    endtask

    // out_ready driver
    initial begin
        forever begin
            @(posedge clk);
            #1;
            case (ready_mode)
                0: out_ready = 1'b1;
                1: out_ready = 1'($urandom_range(0, 1));
                default: out_ready = 1'b0;
            endcase
        end
    end

    // Monitor: compares each transfer with the scoreboard head, checks hold stability and done timing.
    always @(negedge clk) begin
        samp_t e;
        samp_t cur;
        if (rst_n) begin
            cur = '{x: Xin, y: Yin, a: angle, q: quadrant};
            if (out_valid && !out_ready) begin
                hold_cycles++;
                if (hold_valid) chk("hold_stable", 64'(cur), 64'(hold_s));
                hold_s     = cur;
                hold_valid = 1'b1;
            end else begin
                hold_valid = 1'b0;
            end
            if (out_valid && out_ready) begin
                xfer_cnt++;
                $display("[TB] xfer %0d q=%0d angle=%h Xin=%0d Yin=%0d", xfer_cnt, quadrant, angle,
                         $signed(Xin), $signed(Yin));
                if (exp_q.size() == 0) begin
                    chk("unexpected_sample", 64'(1), 64'(0));
                end else begin
                    e = exp_q.pop_front();
                    chk("Xin", 64'(Xin), 64'(e.x));
                    chk("Yin", 64'(Yin), 64'(e.y));
                    chk("angle", 64'(angle), 64'(e.a));
                    chk("quadrant", 64'(quadrant), 64'(e.q));
                end
            end
            if (done) begin
                done_cnt++;
                chk("done_after_last", 64'(exp_q.size()), 64'(0));
            end
        end else begin
            hold_valid = 1'b0;
        end
    end

    task automatic push_burst(input logic [31:0] init, input logic [31:0] inc, input int n);
        logic [31:0] p;
        p = init;
        for (int i = 0; i < n; i++) begin
            exp_q.push_back(model(p));
            p = p + inc;
        end
    endtask

    task automatic run_start(input logic [31:0] init, input logic [31:0] inc, input logic [15:0] len,
                             input logic with_stop, input int n_push);
        push_burst(init, inc, n_push);
        @(posedge clk);
        #1;
        phase_init = init;
        phase_inc  = inc;
        burst_len  = len;
        start      = 1'b1;
        stop       = with_stop;
        @(posedge clk);
        #1;
        start      = 1'b0;
        stop       = 1'b0;
        phase_init = $urandom;
        phase_inc  = $urandom;
        burst_len  = 16'($urandom_range(1, 9));
        chk("first_valid_latency", 64'(out_valid), 64'(1));
        chk("busy_in_run", 64'(busy), 64'(1));
    endtask

    task automatic wait_done(input int done_before);
        logic got;
        got = 1'b0;
        for (int i = 0; i < 600; i++) begin
            @(negedge clk);
            #1;
            if (done) begin
                got = 1'b1;
                break;
            end
        end
        chk("done_timeout", 64'(got), 64'(1));
        if (got) begin
            chk("busy_at_done", 64'(busy), 64'(0));
            chk("valid_at_done", 64'(out_valid), 64'(0));
            chk("queue_empty_at_done", 64'(exp_q.size()), 64'(0));
            @(negedge clk);
            #1;
            chk("done_one_cycle", 64'(done), 64'(0));
            chk("done_count", 64'(done_cnt), 64'(done_before + 1));
        end
    endtask

    task automatic wait_xfer(input int target);
        logic got;
        got = 1'b0;
        for (int i = 0; i < 300; i++) begin
            @(negedge clk);
            #1;
            if (xfer_cnt >= target) begin
                got = 1'b1;
                break;
            end
        end
        chk("xfer_timeout", 64'(got), 64'(1));
    endtask

    initial begin
        int base;
        int dbefore;
        logic [31:0] r_init, r_inc;
        logic [15:0] r_len;

        // Reset values
        #12;
        chk("rst_valid", 64'(out_valid), 64'(0));
        chk("rst_busy", 64'(busy), 64'(0));
        chk("rst_done", 64'(done), 64'(0));
        chk("rst_payload", 64'({Xin, Yin} | 64'(angle) | 64'(quadrant)), 64'(0));
        rst_n = 1'b1;
        repeat (2) @(posedge clk);

        // Reset mid-run
        ready_mode = 0;
        run_start(32'h1234_5678, 32'h0badcafe, 16'd0, 1'b0, 200);
        repeat (4) @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        chk("async_rst_valid", 64'(out_valid), 64'(0));
        chk("async_rst_busy", 64'(busy), 64'(0));
        chk("async_rst_payload", 64'({Xin, Yin} | 64'(angle) | 64'(quadrant)), 64'(0));
        exp_q.delete();
        dbefore = done_cnt;
        @(posedge clk);
        #2;
        rst_n = 1'b1;
        repeat (5) @(negedge clk);
        #1;
        chk("valid_after_release", 64'(out_valid), 64'(0));
        chk("no_done_on_reset", 64'(done_cnt), 64'(dbefore));

        // Basic burst of four in quadrant 0
        dbefore = done_cnt;
        run_start(32'h0, 32'h1000_0000, 16'd4, 1'b0, 4);
        wait_done(dbefore);

        // Quadrant wrap
        dbefore = done_cnt;
        run_start(32'hF000_0000, 32'h6000_0000, 16'd3, 1'b0, 3);
        wait_done(dbefore);

        // Backpressure on the first sample
        ready_mode = 2;
        repeat (2) @(posedge clk);
        dbefore = done_cnt;
        base = xfer_cnt;
        hold_cycles = 0;
        run_start($urandom, $urandom, 16'd3, 1'b0, 3);
        repeat (5) @(posedge clk);
        ready_mode = 0;
        wait_done(dbefore);
        chk("backpressure_hold_cycles", 64'(hold_cycles), 64'(5));
        chk("backpressure_xfers", 64'(xfer_cnt - base), 64'(3));

        // Continuous run, start ignored in RUN, stop coincident with a transfer
        dbefore = done_cnt;
        base = xfer_cnt;
        run_start(32'h0, 32'h0100_0000, 16'd0, 1'b0, 11);
        wait_xfer(base + 5);
        @(posedge clk);
        #1;
        start      = 1'b1;
        phase_init = 32'h8000_0000;
        phase_inc  = 32'h0300_0000;
        burst_len  = 16'd3;
        @(posedge clk);
        #1;
        start = 1'b0;
        wait_xfer(base + 10);
        @(posedge clk);
        #1;
        stop = 1'b1;
        @(posedge clk);
        #1;
        stop = 1'b0;
        chk("stop_valid_low", 64'(out_valid), 64'(0));
        chk("stop_busy_low", 64'(busy), 64'(0));
        repeat (4) @(negedge clk);
        #1;
        chk("stop_xfer_count", 64'(xfer_cnt - base), 64'(11));
        chk("stop_queue_empty", 64'(exp_q.size()), 64'(0));
        chk("stop_no_done", 64'(done_cnt), 64'(dbefore));

        // start and stop together in IDLE, zero increment
        dbefore = done_cnt;
        run_start(32'h9abc_def0, 32'h0, 16'd2, 1'b1, 2);
        wait_done(dbefore);

        // Randomized bursts under random backpressure
        ready_mode = 1;
        for (int t = 0; t < 8; t++) begin
            r_init  = $urandom;
            r_inc   = $urandom;
            r_len   = 16'($urandom_range(1, 7));
            dbefore = done_cnt;
            run_start(r_init, r_inc, r_len, 1'b0, int'(r_len));
            wait_done(dbefore);
        end
        ready_mode = 0;

        repeat (3) @(posedge clk);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    // Watchdog
    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/cordic_phase_sequencer.md
Name: cordic_phase_sequencer

Overview:
- Upstream feeder for the CORDIC_ALGO rotation stage.
- Generates a burst or continuous stream of rotation requests from a 32-bit phase accumulator (NCO style), with a valid/ready handshake.
- Folds each phase into the CORDIC convergence range by quadrant pre-rotation, so CORDIC_ALGO only ever sees a residual angle in [0°, 90°).
- Outputs Xin/Yin/angle connect directly to CORDIC_ALGO. The quadrant tag is for downstream bookkeeping.

Parameters:
- WIDTH, 32, width of Xin/Yin (two's complement).
- GAIN_K, 163007430, CORDIC gain-compensated magnitude loaded as the unit vector.
- CNT_W, 16, width of burst_len and the internal sample counter.

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- start  in  1  one-cycle request to begin a sequence
- stop  in  1  one-cycle abort request
- phase_init  in  32  starting phase; 2^32 = 360°
- phase_inc  in  32  per-sample phase step, unsigned, mod 2^32
- burst_len  in  CNT_W  samples to issue; 0 = continuous
- out_ready  in  1  consumer accepts the sample (tie high for CORDIC_ALGO)
- out_valid  out  1  Xin/Yin/angle/quadrant valid
- Xin  out  WIDTH  pre-rotated start vector X
- Yin  out  WIDTH  pre-rotated start vector Y
- angle  out  32  residual angle, range [0, 2^30)
- quadrant  out  2  phase[31:30] of the current sample
- busy  out  1  high in RUN
- done  out  1  one-cycle pulse when a burst completes normally

Behaviour:
- Reset values (async on rst_n low, all outputs registered):
  - out_valid=0, busy=0, done=0, Xin=0, Yin=0, angle=0, quadrant=0.
  - State IDLE; accumulator and counter cleared.
- FSM has two states, IDLE and RUN. done is a registered pulse, not a state.
- IDLE:
  - start=1 latches phase_inc and burst_len and loads the accumulator with phase_init.
  - Next edge: enter RUN. Sample 0 is presented with out_valid=1 and busy=1.
  - Latency from start edge to first valid is 1 cycle.
  - stop in IDLE is ignored. start and stop together in IDLE: start wins.
- RUN handshake:
  - A transfer occurs on a cycle where out_valid && out_ready.
  - While out_valid && !out_ready, all outputs hold stable.
  - On transfer: accumulator += latched inc (wraps mod 2^32, no saturation) and counter += 1. The next sample appears the following cycle.
  - With out_ready held high, one sample is issued per clock.
- Burst termination:
  - When a transfer makes counter == burst_len (burst_len != 0), go to IDLE next edge.
  - On that edge: out_valid=0, busy=0, done=1 for exactly one cycle.
  - burst_len=0: run until stop; the counter wraps freely and is ignored.
- stop in RUN:
  - Next edge: IDLE, out_valid=0, busy=0, done stays 0.
  - If a transfer happens in the same cycle as stop, that sample is counted as delivered; nothing further is issued.
- start in RUN is ignored. Inputs phase_init, phase_inc and burst_len are sampled only at an accepted start.
- Quadrant fold, with p = phase for the presented sample and q = p[31:30]:
  - angle = {2'b00, p[29:0]}
  - q=0: Xin=+K, Yin=0
  - q=1: Xin=0, Yin=+K
  - q=2: Xin=-K, Yin=0
  - q=3: Xin=0, Yin=-K
  - K = GAIN_K, negation is two's complement at WIDTH.
- Reset asserted mid-burst: immediate return to the reset values. No done pulse, and no sample is resumed after release.

Decomposition:
- Package cordic_pkg holds:
  - ANGLE_W=32
  - QUARTER=32'h4000_0000
  - GAIN_K
  - seq_state_t enum {IDLE, RUN}
  - quadrant_t (2-bit)
- One natural sub-module, cordic_quadrant_fold: combinational phase → {Xin, Yin, angle, quadrant}. It is instantiated once; its outputs feed the output registers.

Test Plan:
1. Reset mid-RUN: assert rst_n=0 during a continuous run → all outputs 0 asynchronously; after release, out_valid stays 0 until a new start.
2. start with phase_init=0, phase_inc=0x1000_0000, burst_len=4, out_ready=1 → four samples on consecutive cycles:
   - angles 0, 0x1000_0000, 0x2000_0000, 0x3000_0000, all q=0, Xin=163007430, Yin=0.
   - Then done pulses once and busy drops.
3. Quadrant and wrap: phase_init=0xF000_0000, phase_inc=0x6000_0000, burst_len=3 →
   - sample 1: q=3, angle=0x3000_0000, Xin=0, Yin=-163007430.
   - sample 2: q=1, angle=0x1000_0000, Xin=0, Yin=+163007430.
   - sample 3: q=2, angle=0x3000_0000, Xin=-163007430, Yin=0.
4. Backpressure: burst_len=3, out_ready low for 5 cycles after the first valid → first sample held stable all 5 cycles; exactly 3 transfers total; done only after the 3rd.
5. Continuous and stop: burst_len=0, phase_inc=0x0100_0000; assert stop after 10 transfers, with a transfer in the same cycle → 11 samples delivered, out_valid=0 next cycle, done never asserted; a further start during RUN is ignored.
6. Start and stop together in IDLE → sequence starts. phase_inc=0 → constant angle repeated for burst_len=2, then done.
